// File: rtl/reset_sequencer.sv
// Merges async/sw reset requests into staged active-low resets; assert 1 edge after req, outputs stretched >= STRETCH_CYCLES.
// Release order fixed: channel 0 first, then one channel every STEP_CYCLES; no backpressure.
module reset_sequencer #(
    parameter int NUM_SRC        = 2,
    parameter int SYNC_STAGES    = 3,
    parameter int NUM_OUT        = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int STEP_CYCLES    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_resetn,
    input  logic               sw_reset,
    output logic [NUM_OUT-1:0] resetn_out,
    output logic               busy,
    output logic               all_released
);

    localparam int CW = $clog2(STRETCH_CYCLES + 1);
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam int IW = $clog2(NUM_OUT + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(STRETCH_CYCLES - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    state_t                              state_q, state_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [SW-1:0]                       scnt_q, scnt_d;
    logic [IW-1:0]                       idx_q, idx_d;
    logic [NUM_OUT-1:0]                  resetn_q, resetn_d;
    logic                                req;

    // Sync flops clear to 0 so that block reset itself reads as a pending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_resetn};
        end
    end

    assign req = reset | sw_reset | ~&sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            scnt_q   <= '0;
            idx_q    <= '0;
            resetn_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            scnt_q   <= scnt_d;
            idx_q    <= idx_d;
            resetn_q <= resetn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        scnt_d   = scnt_q;
        idx_d    = idx_q;
        resetn_d = resetn_q;
        if (req) begin
            // A request wins over any release due on the same edge.
            state_d  = HOLD;
            cnt_d    = '0;
            scnt_d   = '0;
            idx_d    = '0;
            resetn_d = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == CNT_LAST) begin
                        resetn_d[0] = 1'b1;
                        idx_d       = IW'(1);
                        scnt_d      = '0;
                        state_d     = (NUM_OUT == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (scnt_q == SCNT_LAST) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (IW'(i) == idx_q) resetn_d[i] = 1'b1;
                        end
                        scnt_d = '0;
                        idx_d  = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) state_d = RUN;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d  = HOLD;
                    resetn_d = '0;
                end
            endcase
        end
    end

    assign resetn_out   = resetn_q;
    assign busy         = ~&resetn_q;
    assign all_released = &resetn_q;

endmodule
